// File: rtl/bcd_counter3_if.sv
// Control/data bundle between the switch/button front end and the BCD counter.
// The master drives the controls; the slave returns the digits and the step pulses.
interface bcd_counter3_if;
  logic        en;
  logic        up;
  logic        load;
  logic [11:0] load_value;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic        tick;
  logic        wrap;

  modport master (
    output en, up, load, load_value,
    input  digit0, digit1, digit2, tick, wrap
  );

  modport slave (
    input  en, up, load, load_value,
    output digit0, digit1, digit2, tick, wrap
  );
endinterface

// File: rtl/bcd_counter3.sv
// Three-digit BCD up/down counter (000-999) stepped by an internal prescaler,
// with a clamped synchronous parallel load; feeds the seven-segment scan stage.
module bcd_counter3 #(
  parameter int TICK_DIV = 100000000,
  parameter int PRESC_W  = 27
) (
  input  logic          clk,
  input  logic          BTN0,
  bcd_counter3_if.slave bus
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]  presc_q;
  logic [2:0][3:0]     dig_q, step_d, load_d;
  logic                tick_q, wrap_q, wrap_d;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    logic cy;
    step_d = dig_q;
    cy     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (cy) begin
        if (bus.up) begin
          if (dig_q[i] >= 4'd9) step_d[i] = 4'd0;
          else begin
            step_d[i] = dig_q[i] + 4'd1;
            cy        = 1'b0;
          end
        end else begin
          if (dig_q[i] == 4'd0) step_d[i] = 4'd9;
          else begin
            step_d[i] = dig_q[i] - 4'd1;
            cy        = 1'b0;
          end
        end
      end
    end
    wrap_d = cy;
  end

  always_comb begin
    load_d = '0;
    for (int i = 0; i < 3; i++) load_d[i] = clamp9(bus.load_value[4*i +: 4]);
  end

  always_ff @(posedge clk or posedge BTN0) begin
    if (BTN0) begin
      presc_q <= '0;
      dig_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      presc_q <= '0;
      dig_q   <= load_d;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.en) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        dig_q   <= step_d;
        tick_q  <= 1'b1;
        wrap_q  <= wrap_d;
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.digit0 = dig_q[0];
  assign bus.digit1 = dig_q[1];
  assign bus.digit2 = dig_q[2];
  assign bus.tick   = tick_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_counter3.sv
// Bench for bcd_counter3: a TICK_DIV=4 instance against an integer reference model,
// and a TICK_DIV=1 instance driven from a table of carry/borrow/load vectors.
module tb_bcd_counter3;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic BTN0 = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  bcd_counter3_if if4();
  bcd_counter3_if if1();

  bcd_counter3 #(.TICK_DIV(TD), .PRESC_W(27)) u4 (.clk(clk), .BTN0(BTN0), .bus(if4));
  bcd_counter3 #(.TICK_DIV(1),  .PRESC_W(27)) u1 (.clk(clk), .BTN0(BTN0), .bus(if1));

  always #5 clk = ~clk;

  // Reference model for the TICK_DIV=4 instance: value kept as a plain integer.
  int m_val, m_pre, m_tick, m_wrap;

  function automatic int nib9(input int n);
    return (n > 9) ? 9 : n;
  endfunction

  function automatic int clampv(input logic [11:0] lv);
    return nib9(int'(lv[11:8])) * 100 + nib9(int'(lv[7:4])) * 10 + nib9(int'(lv[3:0]));
  endfunction

  function automatic int val4();
    return int'(if4.digit2) * 100 + int'(if4.digit1) * 10 + int'(if4.digit0);
  endfunction

  function automatic int val1();
    return int'(if1.digit2) * 100 + int'(if1.digit1) * 10 + int'(if1.digit0);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit en, input bit up, input bit ld, input logic [11:0] lv);
    if (ld) begin
      m_val = clampv(lv); m_pre = 0; m_tick = 0; m_wrap = 0;
    end else if (en) begin
      if (m_pre == TD - 1) begin
        m_pre  = 0;
        m_tick = 1;
        if (up) begin
          m_wrap = (m_val == 999);
          m_val  = (m_val + 1) % 1000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 999) % 1000;
        end
      end else begin
        m_pre++; m_tick = 0; m_wrap = 0;
      end
    end else begin
      m_tick = 0; m_wrap = 0;
    end
  endtask

  task automatic cmp4(input string nm);
    chk({nm, ".val"},  val4(), m_val);
    chk({nm, ".tick"}, int'(if4.tick), m_tick);
    chk({nm, ".wrap"}, int'(if4.wrap), m_wrap);
    chk({nm, ".range"}, int'(if4.digit0 <= 9 && if4.digit1 <= 9 && if4.digit2 <= 9), 1);
  endtask

  // One clock on the TICK_DIV=4 instance: drive at negedge, sample at next negedge.
  task automatic cyc4(input bit en, input bit up, input bit ld, input logic [11:0] lv,
                      input string nm);
    if4.en = en; if4.up = up; if4.load = ld; if4.load_value = lv;
    @(posedge clk);
    model_edge(en, up, ld, lv);
    @(negedge clk);
    cmp4(nm);
  endtask

  typedef struct {
    bit          en;
    bit          up;
    bit          load;
    logic [11:0] lv;
    int          exp_val;
    bit          exp_tick;
    bit          exp_wrap;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int nticks, nwraps, guard;
    tbl[0]  = '{0, 1, 1, 12'h998, 998, 0, 0};
    tbl[1]  = '{1, 1, 0, 12'h000, 999, 1, 0};
    tbl[2]  = '{1, 1, 0, 12'h000,   0, 1, 1};
    tbl[3]  = '{1, 1, 0, 12'h000,   1, 1, 0};
    tbl[4]  = '{0, 0, 1, 12'h001,   1, 0, 0};
    tbl[5]  = '{1, 0, 0, 12'h000,   0, 1, 0};
    tbl[6]  = '{1, 0, 0, 12'h000, 999, 1, 1};
    tbl[7]  = '{1, 0, 0, 12'h000, 998, 1, 0};
    tbl[8]  = '{0, 0, 1, 12'h100, 100, 0, 0};
    tbl[9]  = '{1, 0, 0, 12'h000,  99, 1, 0};
    tbl[10] = '{0, 1, 0, 12'h000,  99, 0, 0};
    tbl[11] = '{1, 1, 1, 12'hFFF, 999, 0, 0};
    tbl[12] = '{1, 1, 0, 12'h000,   0, 1, 1};

    if4.en = 0; if4.up = 1; if4.load = 0; if4.load_value = '0;
    if1.en = 0; if1.up = 1; if1.load = 0; if1.load_value = '0;
    model_reset();

    // Reset state, then count up 40 cycles.
    repeat (2) @(negedge clk);
    cmp4("reset");
    chk("reset.u1", val1(), 0);
    BTN0 = 0;
    nticks = 0; nwraps = 0;
    for (int i = 0; i < 40; i++) begin
      cyc4(1, 1, 0, '0, "countup");
      nticks += int'(if4.tick);
      nwraps += int'(if4.wrap);
    end
    chk("countup.final", val4(), 10);
    chk("countup.ticks", nticks, 10);
    chk("countup.wraps", nwraps, 0);

    // Freeze at prescaler=2; step must come 2 enabled cycles after resuming.
    cyc4(1, 1, 0, '0, "pre1");
    cyc4(1, 1, 0, '0, "pre2");
    for (int i = 0; i < 20; i++) cyc4(0, 0, 0, '0, "freeze");
    chk("freeze.val", val4(), 10);
    cyc4(1, 1, 0, '0, "resume1");
    chk("resume1.tick", int'(if4.tick), 0);
    cyc4(1, 1, 0, '0, "resume2");
    chk("resume2.tick", int'(if4.tick), 1);
    chk("resume2.val", val4(), 11);

    // Load with clamp exactly on the edge where a step is due.
    guard = 0;
    while (m_pre != TD - 1 && guard < 10) begin
      cyc4(1, 1, 0, '0, "align");
      guard++;
    end
    chk("align.pre", m_pre, TD - 1);
    cyc4(1, 1, 1, 12'hFA5, "loadprio");
    chk("loadprio.val", val4(), 995);
    chk("loadprio.tick", int'(if4.tick), 0);
    for (int i = 0; i < TD - 1; i++) begin
      cyc4(1, 1, 0, '0, "postload");
      chk("postload.notick", int'(if4.tick), 0);
    end
    cyc4(1, 1, 0, '0, "postload.step");
    chk("postload.tick", int'(if4.tick), 1);
    chk("postload.val", val4(), 996);

    // Async reset between edges at 537.
    cyc4(0, 1, 1, 12'h537, "load537");
    chk("load537.val", val4(), 537);
    #2 BTN0 = 1;
    #1;
    chk("async.val", val4(), 0);
    chk("async.tick", int'(if4.tick), 0);
    chk("async.wrap", int'(if4.wrap), 0);
    model_reset();
    if4.load = 0;
    @(negedge clk);
    BTN0 = 0;
    for (int i = 0; i < TD; i++) cyc4(1, 1, 0, '0, "afterreset");
    chk("afterreset.val", val4(), 1);

    // Table vectors on the TICK_DIV=1 instance.
    for (int i = 0; i < 13; i++) begin
      if1.en = tbl[i].en; if1.up = tbl[i].up;
      if1.load = tbl[i].load; if1.load_value = tbl[i].lv;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d.val", i), val1(), tbl[i].exp_val);
      chk($sformatf("tbl%0d.tick", i), int'(if1.tick), int'(tbl[i].exp_tick));
      chk($sformatf("tbl%0d.wrap", i), int'(if1.wrap), int'(tbl[i].exp_wrap));
    end
    if1.en = 0; if1.load = 0;

    // Random traffic against the model, starting near the wrap points.
    cyc4(0, 1, 1, 12'h997, "rndseed");
    for (int i = 0; i < 600; i++) begin
      bit          en, up, ld;
      logic [11:0] lv;
      en = ($urandom_range(0, 3) != 0);
      up = ($urandom_range(0, 7) != 0) ? ((i / 100) % 2 == 0) : ~((i / 100) % 2 == 0);
      ld = ($urandom_range(0, 39) == 0);
      lv = 12'($urandom);
      cyc4(en, up, ld, lv, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
